soc_fpga_ram_code_streamer: RTL and testbench

- Read-side initiator for the single-port pattern/code RAM.
- Fetches a programmed block of words from the RAM port, which has 1-cycle registered read latency and reads only when the write enable is low.
- Delivers the words in order on a valid/ready stream to downstream pattern-consuming logic in the aging SoC.
- Uses a 2-entry output buffer and a credit rule so that backpressure never loses a word.

---
 rtl/soc_fpga_ram_code_streamer.sv | 161 ++++++++++++++++
 tb/tb_soc_fpga_ram_code_streamer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/soc_fpga_ram_code_streamer.sv
// soc_fpga_ram_code_streamer
// Reads a programmed block of words from the single-port pattern/code RAM.
// The RAM has a 1-cycle registered read.
// The words are streamed out in address order on a valid/ready interface.
// A 2-entry output buffer and a credit check on every read make sure that
// backpressure never loses a word.
// Optional build macro STREAMER_CLEAR_ON_READ_EN: after each read, once its
// data has been captured, the same address is written with 0.
module soc_fpga_ram_code_streamer #(
  parameter int DATAWIDTH = 2,
  parameter int ADDRWIDTH = 2,
  parameter int LENWIDTH  = ADDRWIDTH + 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [ADDRWIDTH-1:0] StartAddr,
  input  logic [LENWIDTH-1:0]  Length,
  input  logic                 Abort,
  output logic                 Busy,
  output logic                 Done,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic                 RamWriteEnable,
  output logic [DATAWIDTH-1:0] RamDataIn,
  input  logic [DATAWIDTH-1:0] RamDataOut,
  output logic [DATAWIDTH-1:0] StrmData,
  output logic                 StrmValid,
  input  logic                 StrmReady
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} stateT;

  stateT                state, stateNext;
  logic [LENWIDTH-1:0]  issueCnt;
  logic [LENWIDTH-1:0]  popCnt;
  logic                 vld_p1;      // read issued last cycle, data on RamDataOut now
  logic [1:0]           occ;         // buffer occupancy, 0..2
  logic [DATAWIDTH-1:0] bufHead;
  logic [DATAWIDTH-1:0] bufTail;
  logic                 pop;
  logic                 push;
  logic                 credit;
  logic                 issue;
  logic                 startAcc;
  logic                 abortAct;
`ifdef STREAMER_CLEAR_ON_READ_EN
  logic                 clrPend;     // clear-write of the just-read address is due this cycle
`endif

  assign StrmValid = (occ != 2'd0);
  assign StrmData  = bufHead;
  assign pop       = StrmValid && StrmReady;
  assign push      = vld_p1 && !Abort;
  assign startAcc  = (state == IDLE) && Start && !Abort;
  assign abortAct  = Abort && (state != IDLE);
  assign Busy      = (state == FETCH) || (state == DRAIN);
  assign RamDataIn = '0;

  // A read may only be issued if its word is guaranteed a buffer slot when it returns.
  assign credit = ({1'b0, occ} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});

`ifdef STREAMER_CLEAR_ON_READ_EN
  assign issue          = (state == FETCH) && !Abort && (issueCnt != '0) && credit && !clrPend;
  assign RamWriteEnable = clrPend && !Abort;
`else
  assign issue          = (state == FETCH) && !Abort && (issueCnt != '0) && credit;
  assign RamWriteEnable = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; abort wins over everything outside IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startAcc) stateNext = (Length != '0) ? FETCH : FINISH;
      FETCH:   if (Abort) stateNext = IDLE;
               else if (issue && (issueCnt == LENWIDTH'(1))) stateNext = DRAIN;
      DRAIN:   if (Abort) stateNext = IDLE;
               else if (pop && (popCnt == LENWIDTH'(1))) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Read issue: address, issue/pop counters, in-flight flag
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RamAddr  <= '0;
      issueCnt <= '0;
      popCnt   <= '0;
      vld_p1   <= 1'b0;
`ifdef STREAMER_CLEAR_ON_READ_EN
      clrPend  <= 1'b0;
`endif
    end else begin
      vld_p1 <= issue;
      if (startAcc && (Length != '0)) begin
        RamAddr  <= StartAddr;
        issueCnt <= Length;
        popCnt   <= Length;
      end else begin
        if (issue) issueCnt <= issueCnt - LENWIDTH'(1);
        if (pop && !abortAct) popCnt <= popCnt - LENWIDTH'(1);
`ifdef STREAMER_CLEAR_ON_READ_EN
        // The address is held through the clear-write and advanced after it
        if (abortAct) clrPend <= 1'b0;
        else if (issue) clrPend <= 1'b1;
        else if (clrPend) begin
          clrPend <= 1'b0;
          RamAddr <= RamAddr + ADDRWIDTH'(1);
        end
`else
        if (issue) RamAddr <= RamAddr + ADDRWIDTH'(1);
`endif
      end
    end
  end

  // Output buffer: push the returning word, pop on handshake; abort flushes
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      occ     <= 2'd0;
      bufHead <= '0;
      bufTail <= '0;
    end else if (abortAct) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) bufHead <= RamDataOut;
          else             bufTail <= RamDataOut;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          bufHead <= bufTail;
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) bufHead <= RamDataOut;
          else begin
            bufHead <= bufTail;
            bufTail <= RamDataOut;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion pulse, one cycle after FINISH
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Done <= 1'b0;
    else     Done <= (state == FINISH) && !Abort;
  end

endmodule

// File: tb/tb_soc_fpga_ram_code_streamer.sv
// tb_soc_fpga_ram_code_streamer
// Directed and randomized transfers against a behavioural RAM and a
// reference model.
// The model builds the expected word sequence from the RAM image:
// word i = mem[(StartAddr + i) mod depth].
// The model also predicts the Done timing and the RAM contents afterwards.
module tb_soc_fpga_ram_code_streamer;
  localparam int DW    = 2;
  localparam int AW    = 2;
  localparam int LW    = 3;
  localparam int DEPTH = 4;
`ifdef STREAMER_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst, Start, Abort, Busy, Done, RamWriteEnable, StrmValid, StrmReady;
  logic [AW-1:0] StartAddr, RamAddr;
  logic [LW-1:0] Length;
  logic [DW-1:0] RamDataIn, RamDataOut, StrmData;

  logic [DW-1:0] ram[DEPTH];
  logic [DW-1:0] refMem[DEPTH];
  logic          ldEn;
  logic [AW-1:0] ldAddr;
  logic [DW-1:0] ldData;
  int            writes = 0;
  int            checks = 0;
  int            errors = 0;
  int            pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  soc_fpga_ram_code_streamer #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .StartAddr(StartAddr), .Length(Length),
    .Abort(Abort), .Busy(Busy), .Done(Done), .RamAddr(RamAddr),
    .RamWriteEnable(RamWriteEnable), .RamDataIn(RamDataIn), .RamDataOut(RamDataOut),
    .StrmData(StrmData), .StrmValid(StrmValid), .StrmReady(StrmReady)
  );

  always #5 Clk = ~Clk;

  // Single-port RAM, registered read only when not writing; bench preload port
  always @(posedge Clk) begin
    if (ldEn) ram[ldAddr] <= ldData;
    else if (RamWriteEnable) ram[RamAddr] <= RamDataIn;
    else RamDataOut <= ram[RamAddr];
    if (RamWriteEnable) writes <= writes + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic loadWord(input int a, input logic [DW-1:0] d);
    ldEn = 1'b1; ldAddr = AW'(a); ldData = d;
    @(posedge Clk); #1;
    ldEn = 1'b0;
    refMem[a] = d;
  endtask

  // mode: 0 ready always high, 1 fixed toggle pattern, 2 random ready
  task automatic runXfer(input int sa, input int len, input int mode,
                         input int abortAt, input int againAt);
    logic [DW-1:0] expQ[$];
    int            firstValid, lastPop, doneCnt, doneAt, wb;
    logic          prevStall;
    logic [DW-1:0] prevData;
    logic [AW-1:0] addrBefore;
    firstValid = -1; lastPop = -1; doneCnt = 0; doneAt = -1;
    prevStall = 1'b0; prevData = '0;
    for (int i = 0; i < len; i++) expQ.push_back(refMem[(sa + i) % DEPTH]);
    wb = writes;
    addrBefore = RamAddr;
    Start = 1'b1; StartAddr = AW'(sa); Length = LW'(len); StrmReady = 1'b1; Abort = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      case (mode)
        1:       StrmReady = (pat[(n - 1) % 8] != 0);
        2:       StrmReady = ($urandom_range(0, 3) != 0);
        default: StrmReady = 1'b1;
      endcase
      Abort = (n == abortAt);
      Start = (n == againAt);
      if (n == againAt) begin
        StartAddr = AW'(2);
        Length = LW'(1);
      end
      @(negedge Clk);
      if (n == 1) chk("busy_start", {31'd0, Busy}, (len != 0) ? 1 : 0);
      if (prevStall) begin
        chk("stall_valid", {31'd0, StrmValid}, 1);
        chk("stall_data", {30'd0, StrmData}, {30'd0, prevData});
      end
      if (StrmValid && firstValid < 0) firstValid = n;
      if (Done) begin
        doneCnt++;
        doneAt = n;
      end
      if (StrmValid && StrmReady) begin
        if (expQ.size() == 0) chk("extra_word", {31'd0, StrmValid}, 0);
        else begin
          chk("word", {30'd0, StrmData}, {30'd0, expQ.pop_front()});
          lastPop = n;
        end
      end
      if (abortAt > 0 && n == abortAt + 1) begin
        chk("abort_valid", {31'd0, StrmValid}, 0);
        chk("abort_busy", {31'd0, Busy}, 0);
      end
      prevStall = StrmValid && !StrmReady && !Abort;
      prevData = StrmData;
      @(posedge Clk); #1;
    end
    Start = 1'b0; Abort = 1'b0; StrmReady = 1'b1;
    chk("first_valid", firstValid, (len != 0) ? 3 : -1);
    if (abortAt == 0) begin
      chk("words_left", expQ.size(), 0);
      chk("done_count", doneCnt, 1);
      chk("done_at", doneAt, (len == 0) ? 2 : lastPop + 2);
      chk("ram_writes", writes - wb, CLR ? len : 0);
      if (CLR) for (int i = 0; i < len; i++) refMem[(sa + i) % DEPTH] = '0;
      for (int a = 0; a < DEPTH; a++) chk("ram_contents", {30'd0, ram[a]}, {30'd0, refMem[a]});
    end else begin
      chk("abort_no_done", doneCnt, 0);
    end
    if (len == 0) chk("zero_len_addr", {30'd0, RamAddr}, {30'd0, addrBefore});
    chk("busy_end", {31'd0, Busy}, 0);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; StrmReady = 1'b0;
    StartAddr = '0; Length = '0; ldEn = 1'b0; ldAddr = '0; ldData = '0;
    #2;
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_addr", {30'd0, RamAddr}, 0);
    chk("rst_we", {31'd0, RamWriteEnable}, 0);
    chk("rst_din", {30'd0, RamDataIn}, 0);
    chk("rst_valid", {31'd0, StrmValid}, 0);
    chk("rst_data", {30'd0, StrmData}, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;

    loadWord(0, 2'd1); loadWord(1, 2'd2); loadWord(2, 2'd3); loadWord(3, 2'd0);
    runXfer(0, 4, 0, 0, 0);      // full block, ready high
    runXfer(3, 3, 0, 0, 0);      // address wrap 3,0,1
    runXfer(0, 4, 1, 0, 2);      // toggling ready, Start while busy ignored
    runXfer(1, 0, 0, 0, 0);      // zero length
    runXfer(0, 4, 0, 4, 0);      // abort one cycle after first valid
    loadWord(0, 2'd1); loadWord(1, 2'd2); loadWord(2, 2'd3); loadWord(3, 2'd0);
    runXfer(0, 1, 0, 0, 0);      // restart after abort
    runXfer(0, 2, 0, 0, 0);      // two passes over the same words
    runXfer(0, 2, 0, 0, 0);

    // Asynchronous reset in the middle of a transfer
    Start = 1'b1; StartAddr = '0; Length = LW'(4); StrmReady = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("pre_reset_valid", {31'd0, StrmValid}, 1);
    Rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, Busy}, 0);
    chk("midrst_valid", {31'd0, StrmValid}, 0);
    chk("midrst_data", {30'd0, StrmData}, 0);
    chk("midrst_addr", {30'd0, RamAddr}, 0);
    chk("midrst_we", {31'd0, RamWriteEnable}, 0);
    @(negedge Clk);
    Rst = 1'b0;
    StrmReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("postrst_done", {31'd0, Done}, 0);
    chk("postrst_busy", {31'd0, Busy}, 0);

    // Randomized RAM images, addresses, lengths and backpressure
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < DEPTH; a++) loadWord(a, DW'($urandom_range(0, 3)));
      runXfer($urandom_range(0, 3), $urandom_range(1, 4), 2, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
